mvm_stream_param: RTL and testbench

- Parametrised successor to the fixed 16x16, 8-bit, single-MAC matrix-vector multiplier.
- Computes y = A*x for a KxK signed matrix A and a K-element signed vector x, using P parallel MAC lanes.
- Operands are loaded serially through a valid/ready input port. Results stream out with valid/ready backpressure and a last marker.
- Adds over the previous generation: matrix/vector retention across runs, selectable saturate/wrap output, and a busy indicator.

---
 rtl/mvm_stream_param.sv | 227 ++++++++++++++++++++++
 tb/tb_mvm_stream_param.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mvm_stream_param.sv
// Streaming KxK signed matrix-vector multiplier with P parallel MAC lanes.
// Operands are retained across runs; results stream out with valid/ready and a last marker.
module mvm_stream_param #(
  parameter int K   = 16,
  parameter int B   = 8,
  parameter int P   = 4,
  parameter int OW  = 2*B,
  parameter int SAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_matrix,
  input  logic          load_vector,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [B-1:0]  data_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last,
  output logic [OW-1:0] data_out,
  output logic          done,
  output logic          busy
);

  localparam int AW = 2*B + $clog2(K);
  localparam int N  = K*K/P;
  localparam int MW = $clog2(K*K);
  localparam int XW = $clog2(K);
  localparam int CW = $clog2(N+1);
  // Narrowing bounds assume OW <= AW, which holds for OW = 2B.
  localparam logic signed [AW-1:0] SAT_MAX = {{(AW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {{(AW-OW+1){1'b1}}, {(OW-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, LOAD_M, LOAD_V, COMPUTE, OUTPUT} state_t;

  state_t                state_q, state_d;
  logic                  m_loaded_q, m_loaded_d;
  logic                  v_loaded_q, v_loaded_d;
  logic [MW-1:0]         load_cnt_q, load_cnt_d;
  logic [CW-1:0]         issue_cnt_q, issue_cnt_d;
  logic [MW-1:0]         mat_base_q, mat_base_d;
  logic [XW-1:0]         vec_base_q, vec_base_d;
  logic [XW-1:0]         row_q, row_d;
  logic signed [AW-1:0]  tree_sum_q, tree_sum_d;
  logic                  tree_valid_q, tree_valid_d;
  logic                  tree_first_q, tree_first_d;
  logic                  tree_last_q, tree_last_d;
  logic [XW-1:0]         tree_row_q, tree_row_d;
  logic signed [AW-1:0]  acc_q, acc_d;
  logic [XW-1:0]         out_idx_q, out_idx_d;
  logic                  done_q, done_d;

  logic signed [B-1:0]   mat_mem [K*K];
  logic signed [B-1:0]   vec_mem [K];
  logic [OW-1:0]         y_mem   [K];

  logic                  mat_we, vec_we, y_we;
  logic signed [2*B-1:0] prod;
  logic signed [AW-1:0]  lane_sum;
  logic signed [AW-1:0]  acc_sum;

  function automatic logic [OW-1:0] narrow(input logic signed [AW-1:0] v);
    if (SAT != 0) begin
      if (v > SAT_MAX) return SAT_MAX[OW-1:0];
      if (v < SAT_MIN) return SAT_MIN[OW-1:0];
    end
    return v[OW-1:0];
  endfunction

  // One row chunk of P products per cycle; rows are contiguous in mat_mem.
  always_comb begin
    prod     = '0;
    lane_sum = '0;
    for (int l = 0; l < P; l++) begin
      prod     = mat_mem[mat_base_q + MW'(l)] * vec_mem[vec_base_q + XW'(l)];
      lane_sum = lane_sum + AW'(prod);
    end
  end

  assign acc_sum = (tree_first_q ? '0 : acc_q) + tree_sum_q;

  always_comb begin
    state_d      = state_q;
    m_loaded_d   = m_loaded_q;
    v_loaded_d   = v_loaded_q;
    load_cnt_d   = load_cnt_q;
    issue_cnt_d  = issue_cnt_q;
    mat_base_d   = mat_base_q;
    vec_base_d   = vec_base_q;
    row_d        = row_q;
    tree_sum_d   = tree_sum_q;
    tree_valid_d = 1'b0;
    tree_first_d = 1'b0;
    tree_last_d  = 1'b0;
    tree_row_d   = tree_row_q;
    acc_d        = acc_q;
    out_idx_d    = out_idx_q;
    done_d       = 1'b0;
    mat_we       = 1'b0;
    vec_we       = 1'b0;
    y_we         = tree_valid_q & tree_last_q;
    if (tree_valid_q) acc_d = acc_sum;

    case (state_q)
      IDLE: begin
        load_cnt_d = '0;
        if (load_matrix) begin
          state_d = LOAD_M;
        end else if (load_vector) begin
          state_d = LOAD_V;
        end else if (start && m_loaded_q && v_loaded_q) begin
          state_d     = COMPUTE;
          issue_cnt_d = '0;
          mat_base_d  = '0;
          vec_base_d  = '0;
          row_d       = '0;
        end
      end
      LOAD_M: begin
        if (in_valid) begin
          mat_we = 1'b1;
          if (load_cnt_q == MW'(K*K-1)) begin
            m_loaded_d = 1'b1;
            state_d    = IDLE;
            load_cnt_d = '0;
          end else begin
            load_cnt_d = load_cnt_q + 1'b1;
          end
        end
      end
      LOAD_V: begin
        if (in_valid) begin
          vec_we = 1'b1;
          if (load_cnt_q == MW'(K-1)) begin
            v_loaded_d = 1'b1;
            state_d    = IDLE;
            load_cnt_d = '0;
          end else begin
            load_cnt_d = load_cnt_q + 1'b1;
          end
        end
      end
      COMPUTE: begin
        // The final cycle only drains the adder-tree register into y.
        if (issue_cnt_q != CW'(N)) begin
          tree_valid_d = 1'b1;
          tree_first_d = (vec_base_q == '0);
          tree_last_d  = (vec_base_q == XW'(K-P));
          tree_row_d   = row_q;
          tree_sum_d   = lane_sum;
          issue_cnt_d  = issue_cnt_q + 1'b1;
          mat_base_d   = mat_base_q + MW'(P);
          if (tree_last_d) begin
            vec_base_d = '0;
            row_d      = row_q + 1'b1;
          end else begin
            vec_base_d = vec_base_q + XW'(P);
          end
        end else begin
          state_d   = OUTPUT;
          done_d    = 1'b1;
          out_idx_d = '0;
        end
      end
      OUTPUT: begin
        if (out_ready) begin
          if (out_idx_q == XW'(K-1)) state_d = IDLE;
          else out_idx_d = out_idx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      m_loaded_q   <= 1'b0;
      v_loaded_q   <= 1'b0;
      load_cnt_q   <= '0;
      issue_cnt_q  <= '0;
      mat_base_q   <= '0;
      vec_base_q   <= '0;
      row_q        <= '0;
      tree_sum_q   <= '0;
      tree_valid_q <= 1'b0;
      tree_first_q <= 1'b0;
      tree_last_q  <= 1'b0;
      tree_row_q   <= '0;
      acc_q        <= '0;
      out_idx_q    <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      m_loaded_q   <= m_loaded_d;
      v_loaded_q   <= v_loaded_d;
      load_cnt_q   <= load_cnt_d;
      issue_cnt_q  <= issue_cnt_d;
      mat_base_q   <= mat_base_d;
      vec_base_q   <= vec_base_d;
      row_q        <= row_d;
      tree_sum_q   <= tree_sum_d;
      tree_valid_q <= tree_valid_d;
      tree_first_q <= tree_first_d;
      tree_last_q  <= tree_last_d;
      tree_row_q   <= tree_row_d;
      acc_q        <= acc_d;
      out_idx_q    <= out_idx_d;
      done_q       <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mat_we) mat_mem[load_cnt_q] <= data_in;
    if (vec_we) vec_mem[load_cnt_q[XW-1:0]] <= data_in;
    if (y_we) y_mem[tree_row_q] <= narrow(acc_sum);
  end

  assign busy      = (state_q != IDLE);
  assign in_ready  = (state_q == LOAD_M) || (state_q == LOAD_V);
  assign out_valid = (state_q == OUTPUT);
  assign out_last  = out_valid && (out_idx_q == XW'(K-1));
  assign data_out  = out_valid ? y_mem[out_idx_q] : '0;
  assign done      = done_q;

endmodule

// File: tb/tb_mvm_stream_param.sv
// Randomized self-checking bench: two instances (P=4 saturating, P=1 wrapping)
// share operand loads and are compared against a plain arithmetic model.
module tb_mvm_stream_param;
  localparam int K = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_matrix, load_vector, start, in_valid;
  logic [7:0]  data_in;
  logic        in_ready  [2];
  logic        out_valid [2];
  logic        out_ready [2];
  logic        out_last  [2];
  logic [15:0] data_out  [2];
  logic        done      [2];
  logic        busy      [2];

  mvm_stream_param #(.K(16), .B(8), .P(4), .OW(16), .SAT(1)) dut0 (
    .clk(clk), .reset(reset), .load_matrix(load_matrix), .load_vector(load_vector),
    .start(start), .in_valid(in_valid), .in_ready(in_ready[0]), .data_in(data_in),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_last(out_last[0]),
    .data_out(data_out[0]), .done(done[0]), .busy(busy[0]));

  mvm_stream_param #(.K(16), .B(8), .P(1), .OW(16), .SAT(0)) dut1 (
    .clk(clk), .reset(reset), .load_matrix(load_matrix), .load_vector(load_vector),
    .start(start), .in_valid(in_valid), .in_ready(in_ready[1]), .data_in(data_in),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_last(out_last[1]),
    .data_out(data_out[1]), .done(done[1]), .busy(busy[1]));

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int cycle  = 0;
  int lat [2];
  logic signed [7:0] stage_a [K][K];
  logic signed [7:0] stage_x [K];
  logic signed [7:0] model_a [K][K];
  logic signed [7:0] model_x [K];
  logic [15:0] exp_y [2][K];
  logic [15:0] cap_y [2][K];
  int  start_edge  [2];
  bit  expect_done [2];
  bit  out_active  [2];
  int  out_idx     [2];
  bit  rand_ready  = 1'b0;
  int  stall_idx   [2];
  int  stall_cnt   [2];
  int  stall_seen  = 0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("[TB] FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, req, req);
  endtask

  task automatic fail_now(input string name);
    checks++;
    $display("[TB] FAIL %s: got timeout, required completion", name);
  endtask

  // Reference: exact dot product, then saturate (instance 0) or wrap (instance 1).
  function automatic logic [15:0] model_y(input int inst, input int row);
    int s = 0;
    for (int j = 0; j < K; j++) s += int'(model_a[row][j]) * int'(model_x[j]);
    if (inst == 0) begin
      if (s > 32767) return 16'h7fff;
      if (s < -32768) return 16'h8000;
    end
    return s[15:0];
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        if (expect_done[i] && (cycle - start_edge[i] == lat[i])) begin
          check_output($sformatf("done_latency%0d", i), {31'b0, done[i]}, 32'd1);
          expect_done[i] = 1'b0;
          out_active[i]  = 1'b1;
          out_idx[i]     = 0;
        end else if (done[i]) begin
          check_output($sformatf("spurious_done%0d", i), {31'b0, done[i]}, 32'd0);
        end
        if (out_active[i]) begin
          check_output($sformatf("out_valid%0d", i), {31'b0, out_valid[i]}, 32'd1);
          check_output($sformatf("data_out%0d_y%0d", i, out_idx[i]), {16'b0, data_out[i]},
                       {16'b0, exp_y[i][out_idx[i]]});
          check_output($sformatf("out_last%0d_y%0d", i, out_idx[i]), {31'b0, out_last[i]},
                       {31'b0, out_idx[i] == K-1});
          if (i == 1 && stall_idx[1] == out_idx[1]) stall_seen++;
          if (out_ready[i]) begin
            cap_y[i][out_idx[i]] = data_out[i];
            out_idx[i]++;
            if (out_idx[i] == K) out_active[i] = 1'b0;
          end
        end else if (out_valid[i]) begin
          check_output($sformatf("spurious_out_valid%0d", i), {31'b0, out_valid[i]}, 32'd0);
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
        if (out_active[i] && out_idx[i] == stall_idx[i] && stall_cnt[i] < 5) begin
          out_ready[i] = 1'b0;
          stall_cnt[i]++;
        end else begin
          out_ready[i] = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
      end
    end
  end

  task automatic load_words(input bit matrix, input bit both_cmds);
    int total, n, guard;
    @(posedge clk); #1;
    load_matrix = matrix | both_cmds;
    load_vector = !matrix | both_cmds;
    @(posedge clk); #1;
    load_matrix = 1'b0;
    load_vector = 1'b0;
    total = matrix ? K*K : K;
    n = 0;
    guard = 0;
    while (n < total && guard < 4*total + 40) begin
      in_valid = ($urandom_range(0, 3) != 0);
      data_in  = matrix ? stage_a[n/K][n%K] : stage_x[n];
      @(negedge clk);
      if (in_valid && in_ready[0]) begin
        if (matrix) model_a[n/K][n%K] = data_in;
        else model_x[n] = data_in;
        n++;
      end
      @(posedge clk); #1;
      guard++;
    end
    in_valid = 1'b0;
    if (n < total) fail_now("load_timeout");
    check_output("in_ready_after_load0", {31'b0, in_ready[0]}, 32'd0);
    check_output("in_ready_after_load1", {31'b0, in_ready[1]}, 32'd0);
  endtask

  task automatic apply_stimulus_start();
    for (int i = 0; i < 2; i++)
      for (int r = 0; r < K; r++) exp_y[i][r] = model_y(i, r);
    @(posedge clk); #1;
    start = 1'b1;
    for (int i = 0; i < 2; i++) begin
      start_edge[i]  = cycle + 1;
      expect_done[i] = 1'b1;
      out_active[i]  = 1'b0;
      stall_cnt[i]   = 0;
    end
    @(posedge clk); #1;
    start = 1'b0;
    check_output("busy_compute0", {31'b0, busy[0]}, 32'd1);
    check_output("busy_compute1", {31'b0, busy[1]}, 32'd1);
  endtask

  task automatic run_compute();
    int guard = 0;
    apply_stimulus_start();
    while ((expect_done[0] || expect_done[1] || out_active[0] || out_active[1]) && guard < 3000) begin
      @(posedge clk);
      guard++;
    end
    if (guard >= 3000) begin
      fail_now("run_timeout");
      for (int i = 0; i < 2; i++) begin expect_done[i] = 1'b0; out_active[i] = 1'b0; end
    end
    #1;
    check_output("busy_after_run0", {31'b0, busy[0]}, 32'd0);
    check_output("busy_after_run1", {31'b0, busy[1]}, 32'd0);
  endtask

  task automatic start_ignored();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check_output("ignored_start_busy0", {31'b0, busy[0]}, 32'd0);
      check_output("ignored_start_busy1", {31'b0, busy[1]}, 32'd0);
    end
  endtask

  task automatic stage_random();
    for (int i = 0; i < K; i++) begin
      stage_x[i] = 8'($urandom);
      for (int j = 0; j < K; j++) stage_a[i][j] = 8'($urandom);
    end
  endtask

  initial begin
    lat[0] = K*K/4 + 1;
    lat[1] = K*K + 1;
    for (int i = 0; i < 2; i++) begin
      stall_idx[i] = -1; stall_cnt[i] = 0; out_idx[i] = 0;
      expect_done[i] = 1'b0; out_active[i] = 1'b0; out_ready[i] = 1'b1;
    end
    reset = 1'b0;
    load_matrix = 1'b0; load_vector = 1'b0; start = 1'b0; in_valid = 1'b0; data_in = '0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check_output("reset_busy", {31'b0, busy[i]}, 32'd0);
      check_output("reset_in_ready", {31'b0, in_ready[i]}, 32'd0);
      check_output("reset_out_valid", {31'b0, out_valid[i]}, 32'd0);
      check_output("reset_out_last", {31'b0, out_last[i]}, 32'd0);
      check_output("reset_done", {31'b0, done[i]}, 32'd0);
      check_output("reset_data_out", {16'b0, data_out[i]}, 32'd0);
    end
    @(posedge clk); #1;
    reset = 1'b1;

    start_ignored();

    // Identity matrix against x = 1..16.
    for (int i = 0; i < K; i++) begin
      stage_x[i] = 8'(i + 1);
      for (int j = 0; j < K; j++) stage_a[i][j] = (i == j) ? 8'sd1 : 8'sd0;
    end
    load_words(1'b1, 1'b0);
    load_words(1'b0, 1'b0);
    run_compute();
    check_output("identity_y0", {16'b0, cap_y[0][0]}, 32'd1);
    check_output("identity_y15", {16'b0, cap_y[0][15]}, 32'd16);
    check_output("identity_p1_y15", {16'b0, cap_y[1][15]}, 32'd16);

    // Every product is +16384; the exact row sum 262144 saturates or wraps to zero.
    for (int i = 0; i < K; i++) begin
      stage_x[i] = -8'sd128;
      for (int j = 0; j < K; j++) stage_a[i][j] = -8'sd128;
    end
    load_words(1'b1, 1'b0);
    load_words(1'b0, 1'b0);
    run_compute();
    check_output("sat_y5", {16'b0, cap_y[0][5]}, 32'd32767);
    check_output("wrap_y5", {16'b0, cap_y[1][5]}, 32'd0);

    // Vector loaded before matrix.
    for (int i = 0; i < K; i++) begin
      stage_x[i] = 8'sd2;
      for (int j = 0; j < K; j++) stage_a[i][j] = 8'(i + 1);
    end
    load_words(1'b0, 1'b0);
    load_words(1'b1, 1'b0);
    run_compute();
    check_output("order_y0", {16'b0, cap_y[0][0]}, 32'd32);
    check_output("order_y15", {16'b0, cap_y[0][15]}, 32'd512);

    // Matrix retained; only the vector is reloaded.
    for (int i = 0; i < K; i++) stage_x[i] = 8'sd1;
    load_words(1'b0, 1'b0);
    run_compute();
    check_output("reuse1_y3", {16'b0, cap_y[0][3]}, 32'd64);
    for (int i = 0; i < K; i++) stage_x[i] = 8'sd3;
    load_words(1'b0, 1'b0);
    run_compute();
    check_output("reuse3_y3", {16'b0, cap_y[0][3]}, 32'd192);
    check_output("reuse3_p1_y15", {16'b0, cap_y[1][15]}, 32'd768);

    // Hold off the P=1 instance while it presents y[3].
    stage_random();
    load_words(1'b1, 1'b0);
    load_words(1'b0, 1'b0);
    stall_idx[1] = 3;
    stall_seen = 0;
    run_compute();
    check_output("stall_cycles_y3", stall_seen, 32'd6);
    stall_idx[1] = -1;

    // Randomized runs with random backpressure; one uses simultaneous load commands.
    rand_ready = 1'b1;
    for (int t = 0; t < 3; t++) begin
      stage_random();
      load_words(1'b1, t == 1);
      load_words(1'b0, 1'b0);
      run_compute();
    end

    // Reset three cycles into a run aborts it and clears the loaded flags.
    apply_stimulus_start();
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin expect_done[i] = 1'b0; out_active[i] = 1'b0; end
    #1;
    for (int i = 0; i < 2; i++) begin
      check_output("midreset_busy", {31'b0, busy[i]}, 32'd0);
      check_output("midreset_done", {31'b0, done[i]}, 32'd0);
      check_output("midreset_out_valid", {31'b0, out_valid[i]}, 32'd0);
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    start_ignored();
    stage_random();
    load_words(1'b1, 1'b0);
    load_words(1'b0, 1'b0);
    run_compute();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
